shift_loader_ctrl: RTL and testbench

SHIFT_LOADER_CTRL -- requirements
Module: shift_loader_ctrl

---
 rtl/shift_loader_ctrl.sv | 133 +++++++++++++
 tb/tb_shift_loader_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_loader_ctrl.sv
// -----------------------------------------------------------------------------
// shift_loader_ctrl
//
// Controls an external serial-in/parallel-out shift register. It collects one
// frame of WIDTH serial bits, then captures the register's parallel value into
// word_o. The word is held with word_valid_o until the consumer accepts it.
//
// The first accepted bit ends up in word_o[WIDTH-1] and the last in word_o[0].
// This holds when the register shifts toward the MSB, i.e.
// {q[WIDTH-2:0], shift_in}.
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-high
//   start_i       begin / restart a frame
//   bit_i         serial data bit
//   bit_valid_i   bit_i valid this cycle
//   shift_data_i  parallel output of the controlled shift register
//   shift_en_o    shift enable to the shift register (combinational)
//   shift_in_o    serial input to the shift register (always bit_i)
//   word_o        captured frame word
//   word_valid_o  word_o valid, held until word_ready_i
//   word_ready_i  consumer accepts word_o
//   busy_o        high whenever not IDLE
//   count_o       bits accepted in the current frame (0..WIDTH)
//   error_o       one-cycle pulse: a bit arrived while LATCH/VALID and was dropped
// -----------------------------------------------------------------------------
module shift_loader_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic                     bit_i,
    input  logic                     bit_valid_i,
    input  logic [WIDTH-1:0]         shift_data_i,
    output logic                     shift_en_o,
    output logic                     shift_in_o,
    output logic [WIDTH-1:0]         word_o,
    output logic                     word_valid_o,
    input  logic                     word_ready_i,
    output logic                     busy_o,
    output logic [$clog2(WIDTH):0]   count_o,
    output logic                     error_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] word_reg, word_next;
    logic             error_reg, error_next;
    logic             shift_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            word_reg  <= '0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            word_reg  <= word_next;
            error_reg <= error_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        word_next  = word_reg;
        shift_en   = 1'b0;
        // A bit offered while a finished word is pending cannot be stored.
        error_next = bit_valid_i & ((state_reg == LATCH) | (state_reg == VALID));

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = SHIFT;
                    count_next = '0;
                end
            end
            SHIFT: begin
                if (start_i) begin
                    // Restart wins over a bit offered in the same cycle.
                    count_next = '0;
                end else if (bit_valid_i) begin
                    shift_en   = 1'b1;
                    count_next = count_reg + 1'b1;
                    if (count_reg == LAST_COUNT) begin
                        state_next = LATCH;
                    end
                end
            end
            LATCH: begin
                // The register holds the complete frame after the last shift.
                word_next  = shift_data_i;
                count_next = FULL_COUNT;
                state_next = VALID;
            end
            VALID: begin
                // start_i only counts once the word has been accepted.
                if (word_ready_i) begin
                    count_next = '0;
                    state_next = start_i ? SHIFT : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    assign shift_en_o   = shift_en & ~reset;
    assign shift_in_o   = bit_i;
    assign word_o       = word_reg;
    assign word_valid_o = (state_reg == VALID);
    assign busy_o       = (state_reg != IDLE);
    assign count_o      = count_reg;
    assign error_o      = error_reg;

endmodule

// File: tb/tb_shift_loader_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for shift_loader_ctrl.
//
// A behavioural model tracks the frame as a queue of received bits and builds
// the expected word from that queue. The bench also models the external shift
// register, so the DUT captures real parallel data.
//
// The bench runs a table of frame scenarios, hand-written back-to-back and
// reset sequences, and a randomized soak.
// -----------------------------------------------------------------------------
module tb_shift_loader_ctrl;

    localparam int WIDTH = 16;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   start_i = 1'b0;
    logic                   bit_i = 1'b0;
    logic                   bit_valid_i = 1'b0;
    logic [WIDTH-1:0]       shift_data_i;
    logic                   shift_en_o;
    logic                   shift_in_o;
    logic [WIDTH-1:0]       word_o;
    logic                   word_valid_o;
    logic                   word_ready_i = 1'b0;
    logic                   busy_o;
    logic [$clog2(WIDTH):0] count_o;
    logic                   error_o;

    shift_loader_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .bit_i        (bit_i),
        .bit_valid_i  (bit_valid_i),
        .shift_data_i (shift_data_i),
        .shift_en_o   (shift_en_o),
        .shift_in_o   (shift_in_o),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .busy_o       (busy_o),
        .count_o      (count_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    // External shift register driven by the DUT
    logic [WIDTH-1:0] sr = '0;
    always @(posedge clk) if (shift_en_o) sr <= {sr[WIDTH-2:0], shift_in_o};
    assign shift_data_i = sr;

    // Scoreboard counters
    int n_cmp = 0;
    int n_err = 0;
    int err_sum = 0;
    int sh_sum  = 0;
    int wv_sum  = 0;

    // Behavioural model state
    bit               m_collect = 0;
    bit               m_latch   = 0;
    bit               m_hold    = 0;
    bit               q[$];
    logic [WIDTH-1:0] m_word = '0;
    bit               m_err  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int exp_count();
        if (m_collect)          return q.size();
        if (m_latch || m_hold)  return WIDTH;
        return 0;
    endfunction

    function automatic void model_edge(bit s, bit bv, bit b, bit rdy, bit rst);
        if (rst) begin
            m_collect = 0; m_latch = 0; m_hold = 0;
            q.delete(); m_word = '0; m_err = 0;
        end else begin
            m_err = bv && (m_latch || m_hold);
            if (m_collect) begin
                if (s) q.delete();
                else if (bv) begin
                    q.push_back(b);
                    if (q.size() == WIDTH) begin
                        m_collect = 0;
                        m_latch = 1;
                    end
                end
            end else if (m_latch) begin
                m_word = '0;
                foreach (q[i]) m_word[WIDTH-1-i] = q[i];
                m_latch = 0;
                m_hold  = 1;
            end else if (m_hold) begin
                if (rdy) begin
                    m_hold = 0;
                    q.delete();
                    if (s) m_collect = 1;
                end
            end else if (s) begin
                m_collect = 1;
                q.delete();
            end
        end
    endfunction

    // One clock cycle: drive, check combinational outputs, clock, check state.
    task automatic step(input bit s, input bit bv, input bit b, input bit rdy, input bit rst);
        bit exp_sen;
        @(negedge clk);
        start_i = s; bit_valid_i = bv; bit_i = b; word_ready_i = rdy; reset = rst;
        #1;
        exp_sen = !rst && m_collect && bv && !s;
        chk("shift_en", shift_en_o, exp_sen);
        chk("shift_in", shift_in_o, b);
        if (shift_en_o) sh_sum++;
        @(posedge clk);
        model_edge(s, bv, b, rdy, rst);
        #1;
        chk("count", count_o, exp_count());
        chk("word", word_o, m_word);
        chk("word_valid", word_valid_o, m_hold);
        chk("busy", busy_o, m_collect || m_latch || m_hold);
        chk("error", error_o, m_err);
        if (error_o) err_sum++;
        if (word_valid_o) wv_sum++;
    endtask

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_frame(input logic [15:0] data, input int gap, input int restart_at,
                             input int bp, output logic [15:0] got);
        step(1, 0, 0, 0, 0);
        if (restart_at >= 0) begin
            for (int i = 0; i < restart_at; i++) step(0, 1, rbit(), 0, 0);
            chk("pre_restart_count", count_o, restart_at);
            step(1, 1, 1, 0, 0);
            chk("restart_count", count_o, 0);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (gap != 0) step(0, 0, rbit(), 0, 0);
            step(0, 1, data[15-i], 0, 0);
        end
        chk("latch_no_valid", word_valid_o, 0);
        step(0, 0, 0, 1, 0);
        chk("valid_latency", word_valid_o, 1);
        for (int i = 0; i < bp; i++) step(1, 1, rbit(), 0, 0);
        got = word_o;
        step(0, 0, 0, 1, 0);
        chk("idle_after_accept", busy_o, 0);
    endtask

    typedef struct {
        logic [15:0] data;
        int          gap;
        int          restart_at;
        int          bp;
        logic [15:0] exp_word;
        int          exp_err;
        int          exp_shifts;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got;

        tbl[0] = '{16'hA5C3, 0, -1, 0, 16'hA5C3, 0, 16};
        tbl[1] = '{16'hA5C3, 1, -1, 0, 16'hA5C3, 0, 16};
        tbl[2] = '{16'hA5C3, 0, -1, 5, 16'hA5C3, 5, 16};
        tbl[3] = '{16'h1234, 0,  7, 0, 16'h1234, 0, 23};
        tbl[4] = '{16'hFFFF, 0, -1, 0, 16'hFFFF, 0, 16};

        // Reset state
        step(0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_count", count_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_word", word_o, 0);
        step(0, 1, 1, 0, 0);   // bits ignored in IDLE
        chk("idle_ignores_bits", busy_o, 0);

        // Frame scenarios
        foreach (tbl[k]) begin
            err_sum = 0; sh_sum = 0;
            run_frame(tbl[k].data, tbl[k].gap, tbl[k].restart_at, tbl[k].bp, got);
            chk($sformatf("vec%0d_word", k), got, tbl[k].exp_word);
            chk($sformatf("vec%0d_errors", k), err_sum, tbl[k].exp_err);
            chk($sformatf("vec%0d_shifts", k), sh_sum, tbl[k].exp_shifts);
        end

        // Back-to-back frames: accept and start in the same VALID cycle
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < WIDTH; i++) step(0, 1, 1'(16'hA5C3 >> (15 - i)), 0, 0);
        step(0, 0, 0, 0, 0);
        chk("b2b_first_word", word_o, 16'hA5C3);
        step(1, 0, 0, 1, 0);
        chk("b2b_count", count_o, 0);
        chk("b2b_busy", busy_o, 1);
        chk("b2b_not_valid", word_valid_o, 0);
        for (int i = 0; i < WIDTH; i++) step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("b2b_second_word", word_o, 16'hFFFF);
        step(0, 0, 0, 1, 0);

        // Reset mid-frame discards the frame
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, rbit(), 0, 0);
        chk("mid_count", count_o, 9);
        step(0, 1, 1, 1, 1);
        chk("rst_count", count_o, 0);
        chk("rst_word", word_o, 0);
        chk("rst_valid", word_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        wv_sum = 0;
        for (int i = 0; i < 20; i++) step(0, 1, rbit(), 1, 0);
        chk("rst_no_valid", wv_sum, 0);

        // Randomized soak against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7),
                 rbit(),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
